// File: rtl/grid_render_pkg.sv
`timescale 1ns/1ps
// grid_render_pkg: VGA blanking constants, playfield geometry and palette
// shared by the playfield renderer and the game controller.
package grid_render_pkg;

  // Horizontal blanking, in pixel clocks, following the visible part of a line
  localparam int H_FP    = 16;
  localparam int H_SYNC  = 96;
  localparam int H_BP    = 48;
  localparam int H_BLANK = H_FP + H_SYNC + H_BP;

  // Vertical blanking, in lines, following the visible part of a frame
  localparam int V_FP    = 10;
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 33;
  localparam int V_BLANK = V_FP + V_SYNC + V_BP;

  // Scan counter widths (800 columns / 525 lines fit in 10 bits)
  localparam int H_W = 10;
  localparam int V_W = 10;

  // Occupancy grid: 8 columns of 18 cells, cell (x,y) is bit 18*x + y
  localparam int GRID_W    = 8;
  localparam int GRID_H    = 18;
  localparam int GRID_BITS = GRID_W * GRID_H;

  // Counter widths for cell column, cell row and flattened grid index
  localparam int CELL_X_W   = 3;
  localparam int CELL_Y_W   = 5;
  localparam int CELL_IDX_W = 8;

  // Width of the frame drawn around the playfield, in pixels
  localparam int BORDER = 4;

  // Palette, RRRGGGBB
  localparam logic [7:0] COL_BLACK  = 8'h00;
  localparam logic [7:0] COL_BORDER = 8'hFF;
  localparam logic [7:0] COL_EDGE   = 8'h0C;
  localparam logic [7:0] COL_FILL   = 8'h1C;

  // What a pixel shows, before being turned into a colour
  typedef enum logic [1:0] {
    PIX_BLANK,
    PIX_BORDER,
    PIX_EDGE,
    PIX_FILL
  } pix_class_t;

  // Palette lookup for a pixel class
  function automatic logic [7:0] class_colour(input pix_class_t pc);
    logic [7:0] c;
    case (pc)
      PIX_BORDER: c = COL_BORDER;
      PIX_EDGE:   c = COL_EDGE;
      PIX_FILL:   c = COL_FILL;
      default:    c = COL_BLACK;
    endcase
    return c;
  endfunction

  // Flattened grid bit for cell (cx, cy); column-major, 18 cells per column
  function automatic logic [CELL_IDX_W-1:0] cell_index(
    input logic [CELL_X_W-1:0] cx,
    input logic [CELL_Y_W-1:0] cy
  );
    return CELL_IDX_W'(cx) * CELL_IDX_W'(GRID_H) + CELL_IDX_W'(cy);
  endfunction

endpackage

// File: rtl/grid_render_timing.sv
`timescale 1ns/1ps
// vga_timing: pixel enable, scan counters, registered sync pulses and the
// end-of-visible-frame pulse that tells the game controller a frame is drawn.
module vga_timing
  import grid_render_pkg::*;
#(
  parameter int H_ACT = 640,
  parameter int V_ACT = 480
) (
  input  logic           clk,
  input  logic           rst,
  output logic           pe,
  output logic [H_W-1:0] h_cnt,
  output logic [V_W-1:0] v_cnt,
  output logic           hsync,
  output logic           vsync,
  output logic           draw_finish
);

  localparam int H_TOTAL      = H_ACT + H_BLANK;
  localparam int V_TOTAL      = V_ACT + V_BLANK;
  localparam int H_SYNC_FIRST = H_ACT + H_FP;
  localparam int H_SYNC_LAST  = H_SYNC_FIRST + H_SYNC - 1;
  localparam int V_SYNC_FIRST = V_ACT + V_FP;
  localparam int V_SYNC_LAST  = V_SYNC_FIRST + V_SYNC - 1;

  logic h_wrap;
  logic v_wrap;
  logic hsync_next;
  logic vsync_next;
  logic last_visible;

  assign h_wrap       = (h_cnt == H_W'(H_TOTAL - 1));
  assign v_wrap       = (v_cnt == V_W'(V_TOTAL - 1));
  assign hsync_next   = !((h_cnt >= H_W'(H_SYNC_FIRST)) && (h_cnt <= H_W'(H_SYNC_LAST)));
  assign vsync_next   = !((v_cnt >= V_W'(V_SYNC_FIRST)) && (v_cnt <= V_W'(V_SYNC_LAST)));
  assign last_visible = h_wrap && (v_cnt == V_W'(V_ACT - 1));

  // Pixel enable toggles every clock, giving a 25 MHz pixel rate from 50 MHz
  always_ff @(posedge clk) begin
    if (rst) begin
      pe <= 1'b0;
    end else begin
      pe <= ~pe;
    end
  end

  // Column and line counters advance once per pixel enable
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pe) begin
      if (h_wrap) begin
        h_cnt <= '0;
        if (v_wrap) begin
          v_cnt <= '0;
        end else begin
          v_cnt <= v_cnt + V_W'(1);
        end
      end else begin
        h_cnt <= h_cnt + H_W'(1);
      end
    end
  end

  // Sync outputs trail the counters by one clock, matching the colour path;
  // draw_finish fires in the clock where the scan enters the first blank line
  always_ff @(posedge clk) begin
    if (rst) begin
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      draw_finish <= 1'b0;
    end else begin
      hsync       <= hsync_next;
      vsync       <= vsync_next;
      draw_finish <= pe && last_visible;
    end
  end

endmodule

// File: rtl/grid_render.sv
`timescale 1ns/1ps
// grid_render: draws the 8x18 occupancy grid with a border on a VGA screen.
// The grid is sampled once per frame so each frame shows one consistent state.
module grid_render
  import grid_render_pkg::*;
#(
  parameter int H_ACT = 640,
  parameter int V_ACT = 480,
  parameter int CELL  = 24,
  parameter int X0    = 224,
  parameter int Y0    = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [GRID_BITS-1:0] data_updated,
  output logic                 draw_finish,
  output logic                 hsync,
  output logic                 vsync,
  output logic [7:0]           rgb
);

  localparam int H_TOTAL    = H_ACT + H_BLANK;
  localparam int V_TOTAL    = V_ACT + V_BLANK;
  localparam int OFF_W      = (CELL > 1) ? $clog2(CELL) : 1;
  localparam int PF_X_LAST  = X0 + GRID_W * CELL - 1;
  localparam int PF_Y_LAST  = Y0 + GRID_H * CELL - 1;
  localparam int BD_X_FIRST = X0 - BORDER;
  localparam int BD_X_LAST  = PF_X_LAST + BORDER;
  localparam int BD_Y_FIRST = Y0 - BORDER;
  localparam int BD_Y_LAST  = PF_Y_LAST + BORDER;
  localparam int PAD_BITS   = 2 ** CELL_IDX_W;

  logic                  pe;
  logic [H_W-1:0]        h_cnt;
  logic [V_W-1:0]        v_cnt;
  int                    h_pos;
  int                    v_pos;
  logic                  h_wrap;
  logic                  v_wrap;
  logic                  col_start;
  logic                  row_start;
  logic [CELL_X_W-1:0]   cell_x;
  logic [OFF_W-1:0]      off_x;
  logic [CELL_Y_W-1:0]   cell_y;
  logic [OFF_W-1:0]      off_y;
  logic [GRID_BITS-1:0]  snapshot;
  logic [PAD_BITS-1:0]   snap_pad;
  logic                  visible;
  logic                  in_play;
  logic                  in_frame;
  logic                  filled;
  logic                  on_edge;
  pix_class_t            pix_class;

  vga_timing #(
    .H_ACT (H_ACT),
    .V_ACT (V_ACT)
  ) u_timing (
    .clk         (clk),
    .rst         (rst),
    .pe          (pe),
    .h_cnt       (h_cnt),
    .v_cnt       (v_cnt),
    .hsync       (hsync),
    .vsync       (vsync),
    .draw_finish (draw_finish)
  );

  assign h_pos  = int'(h_cnt);
  assign v_pos  = int'(v_cnt);
  assign h_wrap = (h_pos == H_TOTAL - 1);
  assign v_wrap = (v_pos == V_TOTAL - 1);

  // The next counter value is the first playfield column/line
  assign col_start = (X0 == 0) ? h_wrap : (h_pos == X0 - 1);
  assign row_start = (Y0 == 0) ? v_wrap : (v_pos == Y0 - 1);

  // Cell column and in-cell x offset track h_cnt without any division
  always_ff @(posedge clk) begin
    if (rst) begin
      cell_x <= '0;
      off_x  <= '0;
    end else if (pe) begin
      if (col_start) begin
        cell_x <= '0;
        off_x  <= '0;
      end else if (off_x == OFF_W'(CELL - 1)) begin
        cell_x <= cell_x + CELL_X_W'(1);
        off_x  <= '0;
      end else begin
        off_x <= off_x + OFF_W'(1);
      end
    end
  end

  // Cell row and in-cell y offset step once per line, at the column wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      cell_y <= '0;
      off_y  <= '0;
    end else if (pe && h_wrap) begin
      if (row_start) begin
        cell_y <= '0;
        off_y  <= '0;
      end else if (off_y == OFF_W'(CELL - 1)) begin
        cell_y <= cell_y + CELL_Y_W'(1);
        off_y  <= '0;
      end else begin
        off_y <= off_y + OFF_W'(1);
      end
    end
  end

  // Grid is captured only at the frame-done pulse, so updates land between frames
  always_ff @(posedge clk) begin
    if (rst) begin
      snapshot <= '0;
    end else if (draw_finish) begin
      snapshot <= data_updated;
    end
  end

  // Padding lets the cell index be used directly even outside the playfield
  assign snap_pad = {{(PAD_BITS - GRID_BITS){1'b0}}, snapshot};
  assign visible  = (h_pos < H_ACT) && (v_pos < V_ACT);
  assign in_play  = (h_pos >= X0) && (h_pos <= PF_X_LAST) &&
                    (v_pos >= Y0) && (v_pos <= PF_Y_LAST);
  assign in_frame = (h_pos >= BD_X_FIRST) && (h_pos <= BD_X_LAST) &&
                    (v_pos >= BD_Y_FIRST) && (v_pos <= BD_Y_LAST);
  assign filled   = snap_pad[cell_index(cell_x, cell_y)];
  assign on_edge  = (off_x == OFF_W'(CELL - 1)) || (off_y == OFF_W'(CELL - 1));

  // Classify the current pixel; the earliest matching rule decides
  always_comb begin
    pix_class = PIX_BLANK;
    if (!visible) begin
      pix_class = PIX_BLANK;
    end else if (in_frame && !in_play) begin
      pix_class = PIX_BORDER;
    end else if (in_play && filled) begin
      pix_class = on_edge ? PIX_EDGE : PIX_FILL;
    end
  end

  // Colour is registered once, aligned with the registered sync outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb <= COL_BLACK;
    end else begin
      rgb <= class_colour(pix_class);
    end
  end

endmodule

// File: tb/tb_grid_render.sv
`timescale 1ns/1ps
// tb_grid_render: directed check of the grid renderer on a shrunken screen.
// A small reference model predicts every output sample from the bench's own
// clock count; a hand-computed pixel table pins down cell and border colours.
module tb_grid_render;

  localparam int TB_H_ACT  = 24;
  localparam int TB_V_ACT  = 44;
  localparam int TB_CELL   = 2;
  localparam int TB_X0     = 4;
  localparam int TB_Y0     = 4;
  localparam int HT        = TB_H_ACT + 160;
  localparam int VT        = TB_V_ACT + 45;
  localparam int FRAME_PIX = HT * VT;
  localparam int FRAME_CLK = 2 * FRAME_PIX;
  localparam int FIRST_DF  = 2 * HT * TB_V_ACT;
  localparam int NVEC      = 18;

  logic         clk = 1'b0;
  logic         rst;
  logic [143:0] data_updated;
  logic         draw_finish;
  logic         hsync;
  logic         vsync;
  logic [7:0]   rgb;

  typedef struct {
    int         h;
    int         v;
    logic [7:0] rgb;
  } pix_vec_t;

  pix_vec_t     vecs [NVEC];
  int           tests = 0;
  int           failures = 0;
  int           ticks = 0;
  int           last_df_tick = 0;
  int           cur_h = -1;
  int           cur_v = -1;
  bit           df_seen = 1'b0;
  bit           exp_df_prev = 1'b0;
  bit           table_active = 1'b0;
  logic [143:0] bsnap = '0;
  logic [143:0] corner_data;

  grid_render #(
    .H_ACT (TB_H_ACT),
    .V_ACT (TB_V_ACT),
    .CELL  (TB_CELL),
    .X0    (TB_X0),
    .Y0    (TB_Y0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .data_updated (data_updated),
    .draw_finish  (draw_finish),
    .hsync        (hsync),
    .vsync        (vsync),
    .rgb          (rgb)
  );

  always #10 clk = ~clk;

  // Reference colour for pixel (h,v) given a grid snapshot
  function automatic logic [7:0] model_rgb(input int h, input int v, input logic [143:0] snap);
    int pf_xl = TB_X0 + 8 * TB_CELL - 1;
    int pf_yl = TB_Y0 + 18 * TB_CELL - 1;
    bit in_pf;
    bit in_bd;
    int cx, cy, ox, oy;
    if (h >= TB_H_ACT || v >= TB_V_ACT) return 8'h00;
    in_pf = (h >= TB_X0) && (h <= pf_xl) && (v >= TB_Y0) && (v <= pf_yl);
    in_bd = (h >= TB_X0 - 4) && (h <= pf_xl + 4) && (v >= TB_Y0 - 4) && (v <= pf_yl + 4);
    if (in_bd && !in_pf) return 8'hFF;
    if (in_pf) begin
      cx = (h - TB_X0) / TB_CELL;
      cy = (v - TB_Y0) / TB_CELL;
      ox = (h - TB_X0) % TB_CELL;
      oy = (v - TB_Y0) % TB_CELL;
      if (snap[18 * cx + cy]) return (ox == TB_CELL - 1 || oy == TB_CELL - 1) ? 8'h0C : 8'h1C;
    end
    return 8'h00;
  endfunction

  task automatic check_output(input string name, input logic [7:0] actual, input logic [7:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h (tick %0d, h %0d, v %0d)",
               name, actual, expected, ticks, cur_h, cur_v);
    end
  endtask

  task automatic check_int(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic r, input logic [143:0] d);
    rst          = r;
    data_updated = d;
  endtask

  // Compare all outputs of one sample against the model
  task automatic check_sample();
    logic [7:0] e_rgb;
    logic       e_hs, e_vs, e_df;
    int         k, p;
    if (ticks == 0) begin
      e_rgb = 8'h00; e_hs = 1'b1; e_vs = 1'b1; e_df = 1'b0;
      cur_h = -1; cur_v = -1;
    end else begin
      k     = ticks - 1;
      p     = (k / 2) % FRAME_PIX;
      cur_h = p % HT;
      cur_v = p / HT;
      e_rgb = model_rgb(cur_h, cur_v, bsnap);
      e_hs  = !(cur_h >= TB_H_ACT + 16 && cur_h <= TB_H_ACT + 111);
      e_vs  = !(cur_v >= TB_V_ACT + 10 && cur_v <= TB_V_ACT + 11);
      e_df  = (k % 2 == 1) && (p == TB_V_ACT * HT - 1);
    end
    exp_df_prev = e_df;
    check_output("rgb", rgb, e_rgb);
    check_output("hsync", {7'b0, hsync}, {7'b0, e_hs});
    check_output("vsync", {7'b0, vsync}, {7'b0, e_vs});
    check_output("draw_finish", {7'b0, draw_finish}, {7'b0, e_df});
    if (table_active && ticks != 0) begin
      for (int i = 0; i < NVEC; i++) begin
        if (vecs[i].h == cur_h && vecs[i].v == cur_v)
          check_output($sformatf("pix_vec%0d", i), rgb, vecs[i].rgb);
      end
    end
    if (draw_finish === 1'b1) begin
      if (!df_seen) check_int("df_latency", ticks, FIRST_DF);
      else          check_int("df_period", ticks - last_df_tick, FRAME_CLK);
      last_df_tick = ticks;
      df_seen      = 1'b1;
    end
  endtask

  // One clock: update the bench's own time base and snapshot, then sample
  task automatic step_cycle();
    @(posedge clk);
    if (rst) begin
      ticks   = 0;
      bsnap   = '0;
      df_seen = 1'b0;
    end else begin
      ticks++;
      if (exp_df_prev) bsnap = data_updated;
    end
    #1;
    check_sample();
  endtask

  task automatic wait_df(input int limit);
    bit got = 1'b0;
    for (int i = 0; i < limit && !got; i++) begin
      step_cycle();
      if (draw_finish === 1'b1) got = 1'b1;
    end
    tests++;
    if (!got) begin
      failures++;
      $display("[TB] FAIL df_timeout: no draw_finish within %0d clk", limit);
    end
  endtask

  task automatic wait_row(input int row, input int limit);
    bit got = 1'b0;
    for (int i = 0; i < limit && !got; i++) begin
      step_cycle();
      if (cur_v == row) got = 1'b1;
    end
    tests++;
    if (!got) begin
      failures++;
      $display("[TB] FAIL row_timeout: row %0d not reached within %0d clk", row, limit);
    end
  endtask

  initial begin
    // Hand-computed pixels for a frame drawn from bit 0 and bit 143
    vecs[0]  = '{h: 4,  v: 4,  rgb: 8'h1C};
    vecs[1]  = '{h: 5,  v: 4,  rgb: 8'h0C};
    vecs[2]  = '{h: 4,  v: 5,  rgb: 8'h0C};
    vecs[3]  = '{h: 5,  v: 5,  rgb: 8'h0C};
    vecs[4]  = '{h: 6,  v: 4,  rgb: 8'h00};
    vecs[5]  = '{h: 4,  v: 6,  rgb: 8'h00};
    vecs[6]  = '{h: 18, v: 38, rgb: 8'h1C};
    vecs[7]  = '{h: 19, v: 38, rgb: 8'h0C};
    vecs[8]  = '{h: 18, v: 39, rgb: 8'h0C};
    vecs[9]  = '{h: 17, v: 38, rgb: 8'h00};
    vecs[10] = '{h: 0,  v: 0,  rgb: 8'hFF};
    vecs[11] = '{h: 3,  v: 4,  rgb: 8'hFF};
    vecs[12] = '{h: 20, v: 39, rgb: 8'hFF};
    vecs[13] = '{h: 10, v: 40, rgb: 8'hFF};
    vecs[14] = '{h: 23, v: 43, rgb: 8'hFF};
    vecs[15] = '{h: 10, v: 20, rgb: 8'h00};
    vecs[16] = '{h: 24, v: 10, rgb: 8'h00};
    vecs[17] = '{h: 10, v: 44, rgb: 8'h00};

    corner_data      = '0;
    corner_data[0]   = 1'b1;
    corner_data[143] = 1'b1;

    apply_stimulus(1'b1, '0);
    repeat (5) step_cycle();

    // Grid data present at release is not shown until the first frame-done
    apply_stimulus(1'b0, corner_data);
    wait_row(10, FRAME_CLK);

    // Reset in the middle of the visible area, then time the first pulse
    apply_stimulus(1'b1, corner_data);
    repeat (5) step_cycle();
    apply_stimulus(1'b0, corner_data);
    wait_df(FIRST_DF + 16);

    // Frame from the corner snapshot; a mid-frame change must not show yet
    table_active = 1'b1;
    wait_row(20, FRAME_CLK);
    apply_stimulus(1'b0, {144{1'b1}});
    wait_df(FRAME_CLK + 16);
    table_active = 1'b0;

    // Following frame shows every cell filled
    wait_row(6, FRAME_CLK);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/grid_render.md
GRID_RENDER -- requirements
Module: grid_render

Interface
REQ-001 SHALL have parameter H_ACT, default 640, meaning visible pixels per line.
REQ-002 SHALL have parameter V_ACT, default 480, meaning visible lines per frame.
REQ-003 SHALL have parameter CELL, default 24, meaning cell edge length in pixels.
REQ-004 SHALL have parameter X0, default 224, meaning first pixel column of the playfield.
REQ-005 SHALL have parameter Y0, default 24, meaning first line of the playfield.
REQ-006 SHALL have port clk, input, 1 bit: 50 MHz system clock; the only clock.
REQ-007 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port data_updated, input, 144 bits: 8x18 occupancy grid; cell (x,y) is bit 18*x + y.
REQ-009 SHALL have port draw_finish, output, 1 bit: one-clk frame-done pulse to the game controller.
REQ-010 SHALL have port hsync, output, 1 bit: horizontal sync, active low.
REQ-011 SHALL have port vsync, output, 1 bit: vertical sync, active low.
REQ-012 SHALL have port rgb, output, 8 bits: pixel colour, RRRGGGBB.

Function
REQ-013 SHALL generate pixel enable pe on every second clk; counters advance only when pe=1.
REQ-014 SHALL count h_cnt 0..799 and wrap to 0; SHALL increment v_cnt 0..524 at each h_cnt wrap and wrap v_cnt to 0 after 524.
REQ-015 SHALL drive hsync low for h_cnt 656..751 and vsync low for v_cnt 490..491.
REQ-016 SHALL assert draw_finish for exactly one clk, in the pe cycle where v_cnt becomes 480 and h_cnt becomes 0, giving one pulse per 840000 clk.
REQ-017 SHALL latch data_updated into a 144-bit snapshot in the same clk that draw_finish is high; SHALL render every pixel from the snapshot only.
REQ-018 SHALL track cell column, cell row and in-cell offsets with counters (no dividers); cell_x increments every CELL pixels from X0, and cell_y every CELL lines from Y0.
REQ-019 SHALL define the playfield as h 224..415, v 24..455, and the border as h 220..419, v 20..459, excluding the playfield.
REQ-020 SHALL colour pixels by these rules, first match wins: outside the visible area 8'h00; border 8'hFF; filled cell with in-cell offset x=23 or y=23 8'h0C; filled cell 8'h1C; all else 8'h00.
REQ-021 SHALL register rgb, hsync and vsync with identical latency (one clk after the counter update), so colour and sync stay aligned.
REQ-022 SHALL ignore changes on data_updated outside the draw_finish clk; a mid-frame change first appears in the next frame.

Reset
REQ-023 SHALL, while rst=1, set h_cnt=0, v_cnt=0, pe=0, all cell counters=0, snapshot=0, hsync=1, vsync=1, rgb=8'h00 and draw_finish=0.
REQ-024 SHALL, after rst deasserts mid-frame, restart at h_cnt=0, v_cnt=0 with no draw_finish pulse until v_cnt first reaches 480.

Structure
REQ-025 SHALL place the VGA timing constants, grid dimensions (8, 18) and colour constants in a shared package also used by game_ctrl.
REQ-026 SHALL implement timing (pe, h_cnt, v_cnt, sync, draw_finish) as sub-module vga_timing; cell mapping and colour SHALL remain in grid_render.

Verification
REQ-027 SHALL verify reset: rst high for 5 clk -> hsync=1, vsync=1, rgb=0, draw_finish=0; first draw_finish exactly 2*800*480 clk after release.
REQ-028 SHALL verify timing: free run -> hsync period 1600 clk with a 192 clk low pulse; vsync low for 3200 clk per 840000 clk; draw_finish is high for exactly 1 clk per frame.
REQ-029 SHALL verify cell mapping: data_updated bit 0 only -> 8'h1C at h 224..246, v 24..46; 8'h0C at h=247 or v=47; all other playfield pixels 8'h00.
REQ-030 SHALL verify the far corner: bit 143 only -> filled cell at h 392..415, v 432..455; border 8'hFF at h=220 and at v=459.
REQ-031 SHALL verify snapshot isolation: set data_updated=all-ones mid-frame -> current frame has an empty playfield; next frame has all cells filled.
REQ-032 SHALL verify reset mid-frame: rst at v_cnt=300 -> counters return to 0; next draw_finish arrives 768000 clk after release.
